// File: rtl/lc3_execute_pkg.sv
// lc3_execute_pkg: shared definitions for the LC3 execute stage.
//   - LC3 opcode encodings (IR[15:12])
//   - alu_control and pcselect1 encodings
//   - bit positions of the fields packed into E_Control
//   - sign-extension helpers and opcode classification functions
package lc3_execute_pkg;

   localparam int LC3_W = 16;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   // Encoding 2'b11 is deliberately not named: the ALU returns zero for it.
   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_AND = 2'b01,
      ALU_NOT = 2'b10
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      PC1_OFF11 = 2'b00,
      PC1_OFF9  = 2'b01,
      PC1_OFF6  = 2'b10,
      PC1_ZERO  = 2'b11
   } pcsel1_e;

   // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
   localparam int EC_ALU_HI  = 5;
   localparam int EC_ALU_LO  = 4;
   localparam int EC_PCS1_HI = 3;
   localparam int EC_PCS1_LO = 2;
   localparam int EC_PCS2    = 1;
   localparam int EC_OP2SEL  = 0;

   function automatic logic [LC3_W-1:0] sext5(input logic [4:0] v);
      return {{(LC3_W-5){v[4]}}, v};
   endfunction

   function automatic logic [LC3_W-1:0] sext6(input logic [5:0] v);
      return {{(LC3_W-6){v[5]}}, v};
   endfunction

   function automatic logic [LC3_W-1:0] sext9(input logic [8:0] v);
      return {{(LC3_W-9){v[8]}}, v};
   endfunction

   function automatic logic [LC3_W-1:0] sext11(input logic [10:0] v);
      return {{(LC3_W-11){v[10]}}, v};
   endfunction

   // Opcodes whose aluout is the ALU result rather than the computed address.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
   endfunction

   // Opcodes that write a destination register.
   function automatic logic writes_dr(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
             (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
             (op == OP_LEA);
   endfunction

   // Stores carry their data register in IR[11:9] instead of IR[2:0].
   function automatic logic is_store_op(input logic [3:0] op);
      return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
   endfunction

endpackage

// File: rtl/lc3_execute_alu.sv
// lc3_execute_alu: purely combinational LC3 ALU.
//   a, b         : operands (DATA_W bits)
//   alu_control  : 00 add, 01 and, 10 not a, 11 zero
//   result       : selected result
module lc3_execute_alu
   import lc3_execute_pkg::*;
#(
   parameter int DATA_W = LC3_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        alu_control,
   output logic [DATA_W-1:0] result
);

   logic [DATA_W-1:0] sum_bits;
   logic [DATA_W-1:0] and_bits;
   logic [DATA_W-1:0] not_bits;

   assign sum_bits = a + b;

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bitwise
      assign and_bits[gi] = a[gi] & b[gi];
      assign not_bits[gi] = ~a[gi];
   end

   always_comb begin
      result = '0;
      case (alu_control)
         ALU_ADD: result = sum_bits;
         ALU_AND: result = and_bits;
         ALU_NOT: result = not_bits;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/lc3_execute_stage.sv
// lc3_execute_stage: LC3 execute pipeline stage.
//   Inputs : clock, reset (async active-low), E_Control, IR, npc_in,
//            bypass_alu_1/2, bypass_mem_1/2, VSR1, VSR2, W_Control_in,
//            Mem_Control_in, enable_execute, Mem_Bypass_Val
//   Outputs: aluout, pcout, W_Control_out, Mem_Control_out, M_Data, dr, NZP
//            (registered on enable_execute), sr1, sr2 (combinational)
//   Forwarded operands come from the stage's own held aluout (ALU bypass,
//   highest priority) or from Mem_Bypass_Val.
module lc3_execute_stage
   import lc3_execute_pkg::*;
#(
   parameter int DATA_W     = LC3_W,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [5:0]            E_Control,
   input  logic [DATA_W-1:0]     IR,
   input  logic [DATA_W-1:0]     npc_in,
   input  logic                  bypass_alu_1,
   input  logic                  bypass_alu_2,
   input  logic                  bypass_mem_1,
   input  logic                  bypass_mem_2,
   input  logic [DATA_W-1:0]     VSR1,
   input  logic [DATA_W-1:0]     VSR2,
   input  logic [1:0]            W_Control_in,
   input  logic                  Mem_Control_in,
   input  logic                  enable_execute,
   input  logic [DATA_W-1:0]     Mem_Bypass_Val,
   output logic [DATA_W-1:0]     aluout,
   output logic [DATA_W-1:0]     pcout,
   output logic [1:0]            W_Control_out,
   output logic                  Mem_Control_out,
   output logic [DATA_W-1:0]     M_Data,
   output logic [REG_ADDR_W-1:0] dr,
   output logic [2:0]            NZP,
   output logic [REG_ADDR_W-1:0] sr1,
   output logic [REG_ADDR_W-1:0] sr2
);

   logic [3:0]            opcode;
   logic [1:0]            alu_control;
   logic [1:0]            pcselect1;
   logic                  pcselect2;
   logic                  op2select;

   logic [DATA_W-1:0]     operand_a;
   logic [DATA_W-1:0]     src_b;
   logic [DATA_W-1:0]     operand_b;
   logic [DATA_W-1:0]     alu_result;
   logic [DATA_W-1:0]     addr_offset;
   logic [DATA_W-1:0]     addr_base;
   logic [DATA_W-1:0]     addr_sum;

   logic [DATA_W-1:0]     aluout_reg,  aluout_next;
   logic [DATA_W-1:0]     pcout_reg,   pcout_next;
   logic [1:0]            w_ctrl_reg,  w_ctrl_next;
   logic                  mem_ctrl_reg, mem_ctrl_next;
   logic [DATA_W-1:0]     m_data_reg,  m_data_next;
   logic [REG_ADDR_W-1:0] dr_reg,      dr_next;
   logic [2:0]            nzp_reg,     nzp_next;

   assign opcode      = IR[15:12];
   assign alu_control = E_Control[EC_ALU_HI:EC_ALU_LO];
   assign pcselect1   = E_Control[EC_PCS1_HI:EC_PCS1_LO];
   assign pcselect2   = E_Control[EC_PCS2];
   assign op2select   = E_Control[EC_OP2SEL];

   assign sr1 = IR[8:6];
   assign sr2 = is_store_op(opcode) ? IR[11:9] : IR[2:0];

   // Forwarding muxes: ALU bypass reads the currently held aluout register,
   // so it stays correct across stall cycles.
   always_comb begin
      operand_a = VSR1;
      if (bypass_alu_1)
         operand_a = aluout_reg;
      else if (bypass_mem_1)
         operand_a = Mem_Bypass_Val;
   end

   always_comb begin
      src_b = VSR2;
      if (bypass_alu_2)
         src_b = aluout_reg;
      else if (bypass_mem_2)
         src_b = Mem_Bypass_Val;
   end

   assign operand_b = op2select ? src_b : sext5(IR[4:0]);

   lc3_execute_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .a           (operand_a),
      .b           (operand_b),
      .alu_control (alu_control),
      .result      (alu_result)
   );

   // Address generation: base + sign-extended offset, wrapping at 16 bits.
   always_comb begin
      addr_offset = '0;
      case (pcsel1_e'(pcselect1))
         PC1_OFF11: addr_offset = sext11(IR[10:0]);
         PC1_OFF9:  addr_offset = sext9(IR[8:0]);
         PC1_OFF6:  addr_offset = sext6(IR[5:0]);
         PC1_ZERO:  addr_offset = '0;
         default:   addr_offset = '0;
      endcase
   end

   assign addr_base = pcselect2 ? npc_in : operand_a;
   assign addr_sum  = addr_base + addr_offset;

   always_comb begin
      aluout_next   = aluout_reg;
      pcout_next    = pcout_reg;
      w_ctrl_next   = w_ctrl_reg;
      mem_ctrl_next = mem_ctrl_reg;
      m_data_next   = m_data_reg;
      dr_next       = dr_reg;
      // NZP is a one-shot: it clears on any non-capturing edge so a branch
      // is only presented to the next stage once.
      nzp_next      = '0;
      if (enable_execute) begin
         aluout_next   = is_alu_op(opcode) ? alu_result : addr_sum;
         pcout_next    = addr_sum;
         w_ctrl_next   = W_Control_in;
         mem_ctrl_next = Mem_Control_in;
         m_data_next   = src_b;
         dr_next       = writes_dr(opcode) ? IR[11:9] : '0;
         if (opcode == OP_BR)
            nzp_next = IR[11:9];
         else if (opcode == OP_JMP)
            nzp_next = 3'b111;
         else
            nzp_next = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         aluout_reg   <= '0;
         pcout_reg    <= '0;
         w_ctrl_reg   <= '0;
         mem_ctrl_reg <= 1'b0;
         m_data_reg   <= '0;
         dr_reg       <= '0;
         nzp_reg      <= '0;
      end else begin
         aluout_reg   <= aluout_next;
         pcout_reg    <= pcout_next;
         w_ctrl_reg   <= w_ctrl_next;
         mem_ctrl_reg <= mem_ctrl_next;
         m_data_reg   <= m_data_next;
         dr_reg       <= dr_next;
         nzp_reg      <= nzp_next;
      end
   end

   assign aluout          = aluout_reg;
   assign pcout           = pcout_reg;
   assign W_Control_out   = w_ctrl_reg;
   assign Mem_Control_out = mem_ctrl_reg;
   assign M_Data          = m_data_reg;
   assign dr              = dr_reg;
   assign NZP             = nzp_reg;

endmodule

// File: tb/tb_lc3_execute_stage.sv
// tb_lc3_execute_stage: directed and randomized checks of lc3_execute_stage
// against a behavioural model of the execute-stage rules.
module tb_lc3_execute_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  E_Control;
   logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
   logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
   logic [1:0]  W_Control_in;
   logic        Mem_Control_in, enable_execute;
   logic [15:0] aluout, pcout, M_Data;
   logic [1:0]  W_Control_out;
   logic        Mem_Control_out;
   logic [2:0]  dr, NZP, sr1, sr2;

   int tests_run = 0;
   int tests_failed = 0;

   // model state
   logic [15:0] exp_aluout, exp_pcout, exp_mdata;
   logic [1:0]  exp_w;
   logic        exp_m;
   logic [2:0]  exp_dr, exp_nzp;

   always #5 clock = ~clock;

   lc3_execute_stage dut (
      .clock(clock), .reset(reset), .E_Control(E_Control), .IR(IR),
      .npc_in(npc_in), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
      .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
      .VSR1(VSR1), .VSR2(VSR2), .W_Control_in(W_Control_in),
      .Mem_Control_in(Mem_Control_in), .enable_execute(enable_execute),
      .Mem_Bypass_Val(Mem_Bypass_Val), .aluout(aluout), .pcout(pcout),
      .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
      .M_Data(M_Data), .dr(dr), .NZP(NZP), .sr1(sr1), .sr2(sr2)
   );

   // signed value of the low 'bits' bits of v
   function automatic int sx(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   function automatic logic [2:0] model_sr2(input logic [15:0] ir);
      int op;
      op = int'(ir[15:12]);
      return (op == 3 || op == 7 || op == 11) ? ir[11:9] : ir[2:0];
   endfunction

   task automatic model_clear();
      exp_aluout = 0; exp_pcout = 0; exp_mdata = 0;
      exp_w = 0; exp_m = 0; exp_dr = 0; exp_nzp = 0;
   endtask

   // Next model state for one rising edge with the current inputs.
   task automatic model_edge();
      int op, a, bs, b, alu, off, base;
      if (!enable_execute) begin
         exp_nzp = 0;
         return;
      end
      op = int'(IR[15:12]);
      a  = bypass_alu_1 ? int'(exp_aluout) : bypass_mem_1 ? int'(Mem_Bypass_Val) : int'(VSR1);
      bs = bypass_alu_2 ? int'(exp_aluout) : bypass_mem_2 ? int'(Mem_Bypass_Val) : int'(VSR2);
      b  = E_Control[0] ? bs : (sx(int'(IR[4:0]), 5) & 32'hFFFF);
      case (int'(E_Control[5:4]))
         0:       alu = (a + b) % 65536;
         1:       alu = a & b;
         2:       alu = 65535 - a;
         default: alu = 0;
      endcase
      case (int'(E_Control[3:2]))
         0:       off = sx(int'(IR[10:0]), 11);
         1:       off = sx(int'(IR[8:0]), 9);
         2:       off = sx(int'(IR[5:0]), 6);
         default: off = 0;
      endcase
      base = E_Control[1] ? int'(npc_in) : a;
      exp_pcout  = 16'((base + off + 65536) % 65536);
      exp_aluout = (op == 1 || op == 5 || op == 9) ? 16'(alu) : exp_pcout;
      exp_mdata  = 16'(bs);
      exp_dr     = (op inside {1, 5, 9, 2, 6, 10, 14}) ? IR[11:9] : 3'd0;
      exp_nzp    = (op == 0) ? IR[11:9] : (op == 12) ? 3'b111 : 3'b000;
      exp_w      = W_Control_in;
      exp_m      = Mem_Control_in;
   endtask

   // advance one clock with the current inputs; outputs sampled 1 after the edge
   task automatic cycle();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      E_Control = 0; IR = 0; npc_in = 0; VSR1 = 0; VSR2 = 0; Mem_Bypass_Val = 0;
      bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
      W_Control_in = 0; Mem_Control_in = 0; enable_execute = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      E_Control = 6'($urandom); IR = 16'($urandom); npc_in = 16'($urandom);
      VSR1 = 16'($urandom); VSR2 = 16'($urandom); Mem_Bypass_Val = 16'($urandom);
      {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = 4'($urandom);
      W_Control_in = 2'b11; Mem_Control_in = 1; enable_execute = 1;
      repeat (3) @(posedge clock);
      #1;
      model_clear();
      tests_run++;
      if ({aluout, pcout, M_Data, W_Control_out, Mem_Control_out, dr, NZP} !== '0) begin
         tests_failed++;
         $display("FAIL reset_hold: got alu=%h pc=%h md=%h w=%b m=%b dr=%0d nzp=%b required all 0",
                  aluout, pcout, M_Data, W_Control_out, Mem_Control_out, dr, NZP);
      end
      idle_inputs();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         tests_run++;
         if ({aluout, pcout, M_Data, W_Control_out, Mem_Control_out, dr, NZP} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle_%0d: got alu=%h pc=%h nzp=%b required all 0", i, aluout, pcout, NZP);
         end
      end
      $display("[TB] reset: outputs checked during reset and 3 idle cycles");
   endtask

   task automatic test_add_reg();
      idle_inputs();
      IR = 16'h1042; E_Control = 6'h01; VSR1 = 5; VSR2 = 7; enable_execute = 1;
      #1;
      tests_run++;
      if (sr1 !== 3'd1 || sr2 !== 3'd2) begin
         tests_failed++;
         $display("FAIL add_reg_srcs: got sr1=%0d sr2=%0d required sr1=1 sr2=2", sr1, sr2);
      end
      cycle();
      tests_run++;
      if (aluout !== 16'd12 || dr !== 3'd0) begin
         tests_failed++;
         $display("FAIL add_reg: got aluout=%h dr=%0d required aluout=000c dr=0", aluout, dr);
      end
      $display("[TB] add_reg: aluout=%h dr=%0d", aluout, dr);
   endtask

   task automatic test_forwarding();
      idle_inputs();
      IR = 16'h1042; E_Control = 6'h01; enable_execute = 1;
      bypass_alu_1 = 1; bypass_mem_1 = 1; VSR1 = 16'hDEAD; Mem_Bypass_Val = 99; VSR2 = 7;
      cycle();
      tests_run++;
      if (aluout !== 16'd19) begin
         tests_failed++;
         $display("FAIL fwd_alu_priority: got aluout=%h required 0013", aluout);
      end
      $display("[TB] fwd_alu_priority: aluout=%h", aluout);
      bypass_alu_1 = 0; bypass_mem_1 = 0; bypass_mem_2 = 1;
      VSR1 = 5; Mem_Bypass_Val = 3; VSR2 = 16'h7777;
      cycle();
      tests_run++;
      if (aluout !== 16'd8 || M_Data !== 16'd3) begin
         tests_failed++;
         $display("FAIL fwd_mem_b: got aluout=%h M_Data=%h required 0008 0003", aluout, M_Data);
      end
      $display("[TB] fwd_mem_b: aluout=%h M_Data=%h", aluout, M_Data);
   endtask

   task automatic test_add_imm_wrap();
      idle_inputs();
      IR = 16'h167F; E_Control = 6'h00; VSR1 = 16'h0000; enable_execute = 1;
      cycle();
      tests_run++;
      if (aluout !== 16'hFFFF || dr !== 3'd3) begin
         tests_failed++;
         $display("FAIL add_imm_wrap: got aluout=%h dr=%0d required ffff 3", aluout, dr);
      end
      $display("[TB] add_imm_wrap: aluout=%h dr=%0d", aluout, dr);
   endtask

   task automatic test_branch();
      idle_inputs();
      IR = 16'h0A04; npc_in = 16'h3001; E_Control = 6'h06; enable_execute = 1;
      cycle();
      tests_run++;
      if (pcout !== 16'h3005 || aluout !== 16'h3005 || NZP !== 3'b101 || dr !== 3'd0) begin
         tests_failed++;
         $display("FAIL branch: got pc=%h alu=%h nzp=%b dr=%0d required 3005 3005 101 0",
                  pcout, aluout, NZP, dr);
      end
      enable_execute = 0; IR = 16'h0E00; npc_in = 16'h1111;
      cycle();
      tests_run++;
      if (NZP !== 3'b000 || pcout !== 16'h3005) begin
         tests_failed++;
         $display("FAIL branch_oneshot: got nzp=%b pc=%h required 000 3005", NZP, pcout);
      end
      $display("[TB] branch: pcout=%h NZP=%b after stall", pcout, NZP);
   endtask

   task automatic test_store_async_reset();
      idle_inputs();
      IR = 16'h7442; E_Control = 6'h08; VSR1 = 16'h4000; VSR2 = 16'h1234;
      Mem_Control_in = 1; W_Control_in = 2'b10; enable_execute = 1;
      #1;
      tests_run++;
      if (sr2 !== 3'd2) begin
         tests_failed++;
         $display("FAIL store_sr2: got sr2=%0d required 2", sr2);
      end
      cycle();
      tests_run++;
      if (aluout !== 16'h4002 || M_Data !== 16'h1234 || Mem_Control_out !== 1'b1 ||
          W_Control_out !== 2'b10 || dr !== 3'd0) begin
         tests_failed++;
         $display("FAIL store: got alu=%h md=%h m=%b w=%b dr=%0d required 4002 1234 1 10 0",
                  aluout, M_Data, Mem_Control_out, W_Control_out, dr);
      end
      $display("[TB] store: aluout=%h M_Data=%h", aluout, M_Data);
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if ({aluout, pcout, M_Data, W_Control_out, Mem_Control_out, dr, NZP} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: got alu=%h pc=%h md=%h m=%b required all 0",
                  aluout, pcout, M_Data, Mem_Control_out);
      end
      model_clear();
      #1 reset = 1'b1;
      @(posedge clock); #1;
      model_edge();   // realign: capture with the same store inputs was on this edge
      $display("[TB] async_reset: cleared between edges");
   endtask

   task automatic test_random();
      int nfail_before;
      nfail_before = tests_failed;
      // The edge after the reset release captured the store; the model was
      // advanced for it, so check it matches before random traffic.
      tests_run++;
      if (aluout !== exp_aluout || M_Data !== exp_mdata) begin
         tests_failed++;
         $display("FAIL post_reset_capture: got alu=%h md=%h required %h %h",
                  aluout, M_Data, exp_aluout, exp_mdata);
      end
      for (int i = 0; i < 300; i++) begin
         E_Control = 6'($urandom); IR = 16'($urandom); npc_in = 16'($urandom);
         VSR1 = 16'($urandom); VSR2 = 16'($urandom); Mem_Bypass_Val = 16'($urandom);
         {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = 4'($urandom);
         W_Control_in = 2'($urandom); Mem_Control_in = 1'($urandom);
         enable_execute = ($urandom_range(0, 3) != 0);
         #1;
         tests_run++;
         if (sr1 !== IR[8:6] || sr2 !== model_sr2(IR)) begin
            tests_failed++;
            $display("FAIL rand_src[%0d]: IR=%h got sr1=%0d sr2=%0d required %0d %0d",
                     i, IR, sr1, sr2, IR[8:6], model_sr2(IR));
         end
         cycle();
         tests_run++;
         if (aluout !== exp_aluout || pcout !== exp_pcout || M_Data !== exp_mdata ||
             W_Control_out !== exp_w || Mem_Control_out !== exp_m ||
             dr !== exp_dr || NZP !== exp_nzp) begin
            tests_failed++;
            $display("FAIL rand[%0d]: IR=%h EC=%h en=%b got alu=%h pc=%h md=%h w=%b m=%b dr=%0d nzp=%b required alu=%h pc=%h md=%h w=%b m=%b dr=%0d nzp=%b",
                     i, IR, E_Control, enable_execute, aluout, pcout, M_Data, W_Control_out,
                     Mem_Control_out, dr, NZP, exp_aluout, exp_pcout, exp_mdata, exp_w,
                     exp_m, exp_dr, exp_nzp);
         end
      end
      $display("[TB] random: 300 transactions, %0d new failures", tests_failed - nfail_before);
   endtask

   initial begin
      idle_inputs();
      model_clear();
      test_reset();
      test_add_reg();
      test_forwarding();
      test_add_imm_wrap();
      test_branch();
      test_store_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lc3_execute_stage.md
Name: lc3_execute_stage

Overview:
- Responder side of the execute_in bus: the LC3 Execute pipeline stage that consumes the signals driven by the decode stage or the execute_in agent.
- Computes ALU results, effective/branch addresses, store data and NZP branch masks.
- Registers all results on enable_execute toward the memory-access and writeback stages.
- Resolves ALU-to-ALU and MEM-to-ALU forwarding using its own registered aluout and Mem_Bypass_Val.

Parameters:
- DATA_W, 16, datapath width (LC3 fixed; not overridden).
- REG_ADDR_W, 3, register-file index width.

Ports:
- clock  input  1  stage clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- E_Control  input  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- IR  input  16  instruction in execute.
- npc_in  input  16  PC+1 of the instruction.
- bypass_alu_1  input  1  operand1 := registered aluout.
- bypass_alu_2  input  1  operand2 := registered aluout.
- bypass_mem_1  input  1  operand1 := Mem_Bypass_Val.
- bypass_mem_2  input  1  operand2 := Mem_Bypass_Val.
- VSR1  input  16  register-file value of sr1.
- VSR2  input  16  register-file value of sr2.
- W_Control_in  input  2  writeback control, passed through.
- Mem_Control_in  input  1  memory control, passed through.
- enable_execute  input  1  advance/capture strobe.
- Mem_Bypass_Val  input  16  forwarded memory-stage value.
- aluout  output  16  registered ALU result or effective address.
- pcout  output  16  registered computed address.
- W_Control_out  output  2  registered W_Control_in.
- Mem_Control_out  output  1  registered Mem_Control_in.
- M_Data  output  16  registered store data (forwarded operand2 source).
- dr  output  3  registered destination register.
- NZP  output  3  registered branch condition mask.
- sr1  output  3  combinational IR[8:6].
- sr2  output  3  combinational source-2 index.

Behaviour:
- Reset (reset=0, async): aluout, pcout, W_Control_out, Mem_Control_out, M_Data, dr, NZP all 0. sr1/sr2 stay combinational.
- sr1 = IR[8:6].
- sr2 = IR[11:9] for ST(0011), STR(0111), STI(1011); otherwise IR[2:0].
- Forwarding, operand A:
  - bypass_alu_1 → aluout register.
  - else bypass_mem_1 → Mem_Bypass_Val.
  - else VSR1.
  - ALU bypass has priority when both are set.
- Forwarding, operand B source: same rule with the _2 signals and VSR2.
- Operand B:
  - op2select=1 → B source.
  - op2select=0 → sext(IR[4:0]).
- ALU, by alu_control:
  - 00 → A+B, mod 2^16.
  - 01 → A&B.
  - 10 → ~A.
  - 11 → 0.
- Address offset, by pcselect1:
  - 00 → sext(IR[10:0]).
  - 01 → sext(IR[8:0]).
  - 10 → sext(IR[5:0]).
  - 11 → 0.
- Address base: pcselect2=1 → npc_in; pcselect2=0 → operand A. addr = base+offset, mod 2^16.
- Latency: one cycle. Values present with enable_execute=1 at edge N appear on outputs after edge N.
- On an edge with enable_execute=1:
  - aluout ← ALU result for ADD(0001), AND(0101), NOT(1001); ← addr for all other opcodes.
  - pcout ← addr.
  - M_Data ← B source (forwarded, never imm).
  - dr ← IR[11:9] for ADD, AND, NOT, LD, LDR, LDI, LEA; else 0.
  - NZP ← IR[11:9] for BR(0000); 3'b111 for JMP(1100); else 0.
  - W_Control_out and Mem_Control_out ← their inputs.
- On an edge with enable_execute=0: NZP ← 0, so a branch fires only once. All other outputs hold.
- bypass_alu_* always selects the currently held aluout, including after stall cycles.
- Reset mid-stream clears state immediately. The first enabled edge after release captures normally.
- No X-propagation from unused IR fields. Opcodes RTI/reserved are treated as non-ALU, dr=0, NZP=0.

Decomposition:
- Package lc3_execute_pkg holds:
  - opcode localparams (OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_LEA).
  - alu_control enum (ALU_ADD, ALU_AND, ALU_NOT).
  - pcselect1 enum.
  - E_Control field-slice constants.
- One natural sub-module: lc3_execute_alu. Purely combinational: A, B, alu_control → result.
- Forwarding muxes, address adder and output registers stay in the top.

Test Plan:
- Reset: hold reset=0 with random inputs → all registered outputs 0. Release, enable=0 for 3 cycles → outputs stay 0.
- ADD reg: IR=16'h1042, E_Control=6'h01, VSR1=5, VSR2=7, enable=1 → next cycle aluout=12, dr=0; sr1=1, sr2=2 combinationally.
- ADD imm + wrap: IR=16'h167F, E_Control=6'h00, VSR1=16'h0000 → aluout=16'hFFFF, dr=3.
- Forwarding:
  - After aluout=12, issue IR=16'h1042, E_Control=6'h01, bypass_alu_1=1, bypass_mem_1=1, VSR1=16'hDEAD, Mem_Bypass_Val=99, VSR2=7 → aluout=19 (ALU bypass wins).
  - Repeat with only bypass_mem_2=1 and Mem_Bypass_Val=3 → B=3.
- Branch: IR=16'h0A04, npc_in=16'h3001, E_Control=6'h06 → pcout=aluout=16'h3005, NZP=3'b101, dr=0. Next cycle with enable=0 → NZP=0, pcout holds 16'h3005.
- Store + stall + async reset:
  - IR=16'h7442 (STR R2,R1,#2), E_Control=6'h08, VSR1=16'h4000, VSR2=16'h1234, Mem_Control_in=1 → sr2=2, aluout=16'h4002, M_Data=16'h1234, Mem_Control_out=1.
  - Then assert reset mid-cycle → outputs 0 without waiting for a clock edge.
